// File: rtl/telem_ft_packer.sv
// Buffers 88-bit telemetry packets and streams each as a framed burst of 16-bit FT words.
// Optional trailing CRC-16/CCITT word is enabled by defining TELEM_FT_PACKER_CRC_EN.
module telem_ft_packer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] SYNC_WORD  = 16'hA55A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [87:0] packet_data,
  input  logic        packet_valid,
  output logic [15:0] ui_din,
  output logic [1:0]  ui_din_be,
  output logic        ui_din_valid,
  input  logic        ui_din_full,
  output logic [15:0] drop_count,
  output logic        busy
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

`ifdef TELEM_FT_PACKER_CRC_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, DATA = 2'd2, CRC = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, DATA = 2'd2} state_t;
`endif

  state_t         state_r;
  logic [2:0]     idx_r;
  logic [95:0]    frame_r;
  logic [15:0]    din_r;
  logic [1:0]     be_r;
  logic           valid_r;
  logic           busy_r;
  logic [15:0]    drop_r;
  logic [7:0]     seq_r;
  logic           arm_r;
  logic           full_r;
  logic [CW-1:0]  count_r;
  logic [AW-1:0]  wptr_r;
  logic [AW-1:0]  rptr_r;
  logic [95:0]    mem_r [FIFO_DEPTH];

  logic           accept_s;
  logic           push_s;
  logic           pop_s;
  logic           xfer_s;
  logic           last_s;
  logic           valid_nxt_s;
  logic [CW-1:0]  count_nxt_s;

  // Payload word k of a buffered {packet_data, seq} entry.
  function automatic logic [15:0] word_at(input logic [95:0] f, input logic [2:0] k);
    logic [15:0] w;
    case (k)
      3'd0:    w = f[95:80];
      3'd1:    w = f[79:64];
      3'd2:    w = f[63:48];
      3'd3:    w = f[47:32];
      3'd4:    w = f[31:16];
      3'd5:    w = f[15:0];
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

`ifdef TELEM_FT_PACKER_CRC_EN
  // CRC-16/CCITT over the six payload words, MSB first.
  function automatic logic [15:0] crc16(input logic [95:0] f);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 95; i >= 0; i--) begin
      if (c[15] ^ f[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction
`endif

  // Handshake decode and next-cycle buffer occupancy.
  always_comb begin
    accept_s = packet_valid & arm_r;
    push_s   = accept_s & ~full_r;
    xfer_s   = valid_r & ~ui_din_full;
    pop_s    = (state_r == IDLE) && (count_r != {CW{1'b0}});
`ifdef TELEM_FT_PACKER_CRC_EN
    last_s   = xfer_s && (state_r == CRC);
`else
    last_s   = xfer_s && (state_r == DATA) && (idx_r == 3'd5);
`endif
    count_nxt_s = count_r + CW'(push_s) - CW'(pop_s);
    valid_nxt_s = pop_s | (valid_r & ~last_s);
  end

  // Buffer pointers, sequence numbering and overflow accounting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r  <= {AW{1'b0}};
      rptr_r  <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
      full_r  <= 1'b0;
      seq_r   <= 8'd0;
      drop_r  <= 16'd0;
      arm_r   <= 1'b0;
    end else begin
      arm_r   <= 1'b1;
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CW'(FIFO_DEPTH));
      if (accept_s) seq_r <= seq_r + 8'd1;
      if (push_s)   wptr_r <= wptr_r + AW'(1'b1);
      if (pop_s)    rptr_r <= rptr_r + AW'(1'b1);
      if (accept_s && full_r && (drop_r != 16'hFFFF)) drop_r <= drop_r + 16'd1;
    end
  end

  // Buffer storage; contents need no reset because occupancy is tracked by pointers.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wptr_r] <= {packet_data, seq_r};
  end

  // Frame sequencer; the presented word only changes on a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= 3'd0;
      frame_r <= 96'd0;
      din_r   <= 16'h0000;
      be_r    <= 2'b00;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      be_r    <= 2'b11;
      valid_r <= valid_nxt_s;
      busy_r  <= valid_nxt_s | (count_nxt_s != {CW{1'b0}});
      case (state_r)
        IDLE: if (pop_s) begin
          frame_r <= mem_r[rptr_r];
          din_r   <= SYNC_WORD;
          state_r <= SYNC;
        end
        SYNC: if (xfer_s) begin
          din_r   <= word_at(frame_r, 3'd0);
          idx_r   <= 3'd0;
          state_r <= DATA;
        end
        DATA: if (xfer_s) begin
          if (idx_r == 3'd5) begin
`ifdef TELEM_FT_PACKER_CRC_EN
            din_r   <= crc16(frame_r);
            state_r <= CRC;
`else
            din_r   <= 16'h0000;
            state_r <= IDLE;
`endif
          end else begin
            din_r <= word_at(frame_r, idx_r + 3'd1);
            idx_r <= idx_r + 3'd1;
          end
        end
`ifdef TELEM_FT_PACKER_CRC_EN
        CRC: if (xfer_s) begin
          din_r   <= 16'h0000;
          state_r <= IDLE;
        end
`endif
        default: state_r <= IDLE;
      endcase
    end
  end

  assign ui_din       = din_r;
  assign ui_din_be    = be_r;
  assign ui_din_valid = valid_r;
  assign drop_count   = drop_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_telem_ft_packer.sv
// Self-checking bench for telem_ft_packer: fixed vectors, stall/overflow/reset sequences,
// and randomized traffic scored against a byte-level frame model.
module tb_telem_ft_packer;

  localparam int DEPTH = 4;
`ifdef TELEM_FT_PACKER_CRC_EN
  localparam int FL = 8;
`else
  localparam int FL = 7;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [87:0] packet_data = 88'd0;
  logic        packet_valid = 1'b0;
  logic [15:0] ui_din;
  logic [1:0]  ui_din_be;
  logic        ui_din_valid;
  logic        ui_din_full = 1'b0;
  logic [15:0] drop_count;
  logic        busy;

  telem_ft_packer #(.FIFO_DEPTH(DEPTH), .SYNC_WORD(16'hA55A)) dut (
    .clk(clk), .rst_n(rst_n), .packet_data(packet_data), .packet_valid(packet_valid),
    .ui_din(ui_din), .ui_din_be(ui_din_be), .ui_din_valid(ui_din_valid),
    .ui_din_full(ui_din_full), .drop_count(drop_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [87:0]  data;
    logic [111:0] words;
  } vec_t;
  vec_t tbl[3];

  int pass_cnt = 0;
  int tot_cnt = 0;
  int model_seq = 0;
  bit rand_bp = 1'b0;
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];

  // Every accepted word transfer, observed mid-cycle.
  always @(negedge clk) begin
    if (ui_din_valid && !ui_din_full) got_q.push_back(ui_din);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [15:0] qget(input int i);
    if (i < got_q.size()) return got_q[i];
    return 16'hDEAD;
  endfunction

  // Reference frame: split packet into bytes, append seq, pair up, CRC bytewise.
  function automatic void model_frame(input logic [87:0] d, input logic [7:0] s);
    logic [7:0]  b[12];
    logic [15:0] c;
    logic [87:0] t;
    t = d;
    for (int k = 0; k < 11; k++) begin
      b[k] = t[87:80];
      t = t << 8;
    end
    b[11] = s;
    exp_q.push_back(16'hA55A);
    for (int k = 0; k < 6; k++) exp_q.push_back({b[2*k], b[2*k+1]});
    c = 16'hFFFF;
    for (int k = 0; k < 12; k++) begin
      c = c ^ {b[k], 8'h00};
      for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    if (FL == 8) exp_q.push_back(c);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_bp) ui_din_full = ($urandom_range(0, 3) == 0);
  endtask

  // One strobe; keep=0 means the model expects it to be dropped.
  task automatic send(input logic [87:0] d, input bit keep);
    packet_data = d;
    packet_valid = 1'b1;
    if (keep) model_frame(d, model_seq[7:0]);
    model_seq = (model_seq + 1) % 256;
    step();
    packet_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int c;
    c = 0;
    while (got_q.size() < n * FL && c < budget) begin
      step();
      c++;
    end
  endtask

  task automatic compare_stream(input string name);
    chk($sformatf("%s_len", name), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_w%0d", name, i), qget(i), exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [87:0] rnd88();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[87:0];
  endfunction

  initial begin
    tbl[0].data = 88'h0102030405060708090A0B;
    tbl[0].words = 112'hA55A_0102_0304_0506_0708_090A_0B00;
    tbl[1].data = 88'hFFEEDDCCBBAA9988776655;
    tbl[1].words = 112'hA55A_FFEE_DDCC_BBAA_9988_7766_5501;
    tbl[2].data = 88'h123456789ABCDEF0112233;
    tbl[2].words = 112'hA55A_1234_5678_9ABC_DEF0_1122_3302;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_din", ui_din, 16'h0000);
    chk("rst_valid", ui_din_valid, 1'b0);
    chk("rst_be", ui_din_be, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_drop", drop_count, 16'd0);
    rst_n = 1'b1;
    step();
    step();

    // Fixed vectors from idle: SYNC lands two cycles after the strobe
    for (int i = 0; i < 3; i++) begin
      send(tbl[i].data, 1'b1);
      chk($sformatf("v%0d_sync_early", i), ui_din_valid, 1'b0);
      step();
      chk($sformatf("v%0d_sync_at2", i), {ui_din_valid, ui_din}, {1'b1, 16'hA55A});
      chk($sformatf("v%0d_be", i), ui_din_be, 2'b11);
      wait_frames(1, 60);
      chk($sformatf("v%0d_len", i), got_q.size(), FL);
      for (int j = 0; j < 7; j++) begin
        logic [111:0] w;
        w = tbl[i].words << (16 * j);
        chk($sformatf("v%0d_w%0d", i, j), qget(j), w[111:96]);
      end
      if (FL == 8) chk($sformatf("v%0d_crc", i), qget(7), exp_q[7]);
      got_q.delete();
      exp_q.delete();
      step();
      step();
      chk($sformatf("v%0d_idle_busy", i), busy, 1'b0);
    end

    // Backpressure held for 5 cycles on DATA word 2
    send(tbl[0].data, 1'b1);
    for (int c = 0; c < 40; c++) begin
      if (ui_din_valid && ui_din == 16'h0506) break;
      step();
    end
    ui_din_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_din", ui_din, 16'h0506);
      chk("stall_valid", ui_din_valid, 1'b1);
      @(posedge clk);
      #1;
    end
    ui_din_full = 1'b0;
    wait_frames(1, 60);
    compare_stream("stall");

    // Buffer of four fills behind a stalled frame; two further strobes drop
    ui_din_full = 1'b1;
    send(rnd88(), 1'b1);
    for (int c = 0; c < 10 && !ui_din_valid; c++) step();
    for (int k = 0; k < 6; k++) send(rnd88(), k < 4);
    step();
    chk("ovf_drop", drop_count, 16'd2);
    chk("ovf_busy", busy, 1'b1);
    chk("ovf_hold", {ui_din_valid, ui_din}, {1'b1, 16'hA55A});
    ui_din_full = 1'b0;
    wait_frames(5, 200);
    compare_stream("ovf");

    // Reset pulse during DATA word 3 abandons the frame
    send(tbl[0].data, 1'b0);
    for (int c = 0; c < 40; c++) begin
      if (ui_din_valid && ui_din == 16'h0708) break;
      step();
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_din", ui_din, 16'h0000);
    chk("mid_rst_valid", ui_din_valid, 1'b0);
    chk("mid_rst_be", ui_din_be, 2'b00);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_drop", drop_count, 16'd0);
    step();
    step();
    got_q.delete();
    exp_q.delete();
    rst_n = 1'b1;
    packet_data = tbl[2].data;
    packet_valid = 1'b1;
    step();
    packet_valid = 1'b0;
    model_seq = 0;
    send(tbl[1].data, 1'b1);
    wait_frames(1, 60);
    repeat (20) step();
    compare_stream("post_rst");

    // 300 random strobes, no backpressure, seq wraps
    for (int n = 0; n < 300; n++) begin
      for (int c = 0; c < 100 && (n - got_q.size() / FL) >= DEPTH; c++) step();
      send(rnd88(), 1'b1);
      repeat ($urandom_range(0, 6)) step();
    end
    wait_frames(300, 5000);
    compare_stream("wrap");
    chk("wrap_drop", drop_count, 16'd0);
    chk("wrap_seq", model_seq, 45);

    // Random traffic under random backpressure
    rand_bp = 1'b1;
    for (int n = 0; n < 40; n++) begin
      for (int c = 0; c < 200 && (n - got_q.size() / FL) >= DEPTH; c++) step();
      send(rnd88(), 1'b1);
      repeat ($urandom_range(0, 4)) step();
    end
    rand_bp = 1'b0;
    ui_din_full = 1'b0;
    wait_frames(40, 3000);
    compare_stream("bp");
    chk("bp_drop", drop_count, 16'd0);
    step();
    step();
    chk("end_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
